// File: rtl/mux_nx1_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nx1_scan_if
//  Description : Bus bundle for mux_nx1_scan. Carries the packed channel
//                inputs, the manual select, the mode/enable controls and
//                the registered output sample with its status.
//                master : drives I, S, mode, en; observes Y, Y_valid, ch, wrap
//                slave  : the multiplexer side (mirror of master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_nx1_scan_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] I;
    logic [SEL_W-1:0]   S;
    logic               mode;
    logic               en;
    logic [WIDTH-1:0]   Y;
    logic               Y_valid;
    logic [SEL_W-1:0]   ch;
    logic               wrap;

    modport master (
        output I, S, mode, en,
        input  Y, Y_valid, ch, wrap
    );

    modport slave (
        input  I, S, mode, en,
        output Y, Y_valid, ch, wrap
    );
endinterface
`default_nettype wire

// File: rtl/mux_nx1_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_nx1_scan
//  Description : N-to-1 multiplexer with a registered output and two modes.
//                MANUAL : output follows the external select S.
//                SCAN   : an internal sequencer walks channels 0..N-1,
//                         holding each for DWELL enabled cycles.
//  Ports       : clk  - rising-edge clock
//                rst  - synchronous active-high reset
//                bus  - slave modport: I, S, mode, en in; Y, Y_valid, ch,
//                       wrap out (all outputs registered, 1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_scan #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int DWELL = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_nx1_scan_if.slave     bus
);
    localparam int SEL_W = $clog2(N);
    localparam int CNT_W = $clog2(DWELL + 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_y;
    logic               r_valid;
    logic               r_wrap;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_ch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_y_nxt;
    logic               w_valid_nxt;
    logic               w_wrap_nxt;
    logic [WIDTH-1:0]   w_sel_data;
    logic               w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_MANUAL;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        // Disabled cycles hold data/channel/counter and drop the strobes.
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_sel_data  = '0;
        w_hit       = 1'b0;

        if (bus.en) begin
            if (!bus.mode) begin
                w_state_nxt = ST_MANUAL;
                w_ch_nxt    = bus.S;
                w_cnt_nxt   = '0;
            end else if (r_state == ST_MANUAL) begin
                // Entering SCAN always starts a fresh dwell on channel 0.
                w_state_nxt = ST_SCAN;
                w_ch_nxt    = '0;
                w_cnt_nxt   = '0;
            end else begin
                if (r_cnt == CNT_W'(DWELL - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_ch == SEL_W'(N - 1)) begin
                        w_ch_nxt   = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_ch_nxt = r_ch + SEL_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            // Select from the channel being registered this edge, so the
            // advancing edge already carries the new channel's data. An
            // out-of-range manual select matches nothing and yields 0/invalid.
            for (int k = 0; k < N; k++) begin
                if (w_ch_nxt == SEL_W'(k)) begin
                    w_sel_data = bus.I[k*WIDTH +: WIDTH];
                    w_hit      = 1'b1;
                end
            end
            w_y_nxt     = w_sel_data;
            w_valid_nxt = w_hit;
        end
    end

    assign bus.Y       = r_y;
    assign bus.Y_valid = r_valid;
    assign bus.ch      = r_ch;
    assign bus.wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_nx1_scan
//  Description : Self-checking bench for mux_nx1_scan. Two builds run side by
//                side on one clock: N=4/DWELL=4 and N=3/DWELL=1. A reference
//                model derives the scan channel from the number of enabled
//                scan cycles since entry (position / DWELL mod N).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nx1_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_nx1_scan_if #(.WIDTH(8), .N(4)) bus4 ();
    mux_nx1_scan_if #(.WIDTH(8), .N(3)) bus3 ();

    mux_nx1_scan #(.WIDTH(8), .N(4), .DWELL(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    mux_nx1_scan #(.WIDTH(8), .N(3), .DWELL(1)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    typedef struct packed {
        logic [31:0] y;
        logic        valid;
        logic [31:0] ch;
        logic        wrap;
        logic        st;
        logic [31:0] pos;
    } mdl_t;

    int   checks = 0;
    int   errors = 0;
    mdl_t m4 = '0;
    mdl_t m3 = '0;

    function automatic logic [31:0] chan(logic [31:0] iv, logic [31:0] k);
        return (iv >> (k * 8)) & 32'hFF;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic r, logic md, logic e,
                                   logic [31:0] s, logic [31:0] iv,
                                   int n, int dw);
        mdl_t o = m;
        if (r) begin
            o = '0;
        end else if (!e) begin
            o.valid = 1'b0;
            o.wrap  = 1'b0;
        end else if (!md) begin
            o.st    = 1'b0;
            o.pos   = 0;
            o.ch    = s;
            o.wrap  = 1'b0;
            o.valid = (s < 32'(n));
            o.y     = o.valid ? chan(iv, s) : 32'd0;
        end else begin
            o.pos   = m.st ? m.pos + 1 : 32'd0;
            o.ch    = (o.pos / 32'(dw)) % 32'(n);
            o.wrap  = m.st && ((o.pos % 32'(dw * n)) == 0);
            o.y     = chan(iv, o.ch);
            o.valid = 1'b1;
            o.st    = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance both models with the inputs the DUTs sample,
    // then compare every output shortly after the edge.
    task automatic tick();
        @(posedge clk);
        m4 = mstep(m4, rst, bus4.mode, bus4.en, 32'(bus4.S), 32'(bus4.I), 4, 4);
        m3 = mstep(m3, rst, bus3.mode, bus3.en, 32'(bus3.S), 32'(bus3.I), 3, 1);
        #1;
        check("n4_Y",       32'(bus4.Y),       m4.y);
        check("n4_Y_valid", 32'(bus4.Y_valid), 32'(m4.valid));
        check("n4_ch",      32'(bus4.ch),      m4.ch);
        check("n4_wrap",    32'(bus4.wrap),    32'(m4.wrap));
        check("n3_Y",       32'(bus3.Y),       m3.y);
        check("n3_Y_valid", 32'(bus3.Y_valid), 32'(m3.valid));
        check("n3_ch",      32'(bus3.ch),      m3.ch);
        check("n3_wrap",    32'(bus3.wrap),    32'(m3.wrap));
    endtask

    initial begin
        bus4.I = 32'h44332211; bus4.S = '0; bus4.mode = 1'b0; bus4.en = 1'b1;
        bus3.I = 24'h332211;   bus3.S = '0; bus3.mode = 1'b0; bus3.en = 1'b1;

        // Reset with nonzero inputs
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Manual sweep; S=3 is out of range on the N=3 build
        for (int s = 0; s < 4; s++) begin
            bus4.S = 2'(s);
            bus3.S = 2'(s);
            tick();
        end
        check("n4_manual_last_Y", 32'(bus4.Y), 32'h44);
        check("n3_oob_valid",     32'(bus3.Y_valid), 32'd0);

        // Full scan cycle and wrap
        bus4.mode = 1'b1;
        bus3.mode = 1'b1;
        for (int i = 0; i < 17; i++) tick();

        // Re-enter scan, run to ch=1 count=2, then an enable gap
        bus4.mode = 1'b0; bus3.mode = 1'b0;
        tick();
        bus4.mode = 1'b1; bus3.mode = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus4.en = 1'b0; bus3.en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus4.en = 1'b1; bus3.en = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Reset mid-scan, then SCAN -> MANUAL with S=3
        for (int i = 0; i < 2; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus4.mode = 1'b0; bus4.S = 2'd3;
        bus3.mode = 1'b0; bus3.S = 2'd1;
        tick();
        check("n4_scan_to_manual_Y", 32'(bus4.Y), 32'h44);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus4.I = $urandom;
            bus3.I = 24'($urandom);
            bus4.S = 2'($urandom_range(0, 3));
            bus3.S = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus4.mode = ~bus4.mode;
            if ($urandom_range(0, 19) == 0) bus3.mode = ~bus3.mode;
            bus4.en = ($urandom_range(0, 4) != 0);
            bus3.en = ($urandom_range(0, 4) != 0);
            rst     = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
